// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the register-file write port between the issue stage
// (rename tag writes) and NFU functional units (result completions), and
// broadcasts completions on the CDB. A shadow copy of the dependency tags
// drops register writes from completions whose destination was renamed again.
module cdb_arbiter #(
  parameter int NFU = 3,
  parameter int DW  = 16,
  parameter int TW  = 3,
  parameter int RW  = 3
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                issueReq,
  input  logic [RW-1:0]       issueReg,
  input  logic [TW-1:0]       issueTag,
  output logic                issueAck,
  input  logic [NFU-1:0]      fuReq,
  input  logic [NFU*TW-1:0]   fuTag,
  input  logic [NFU*RW-1:0]   fuReg,
  input  logic [NFU*DW-1:0]   fuData,
  output logic [NFU-1:0]      fuAck,
  output logic                wren,
  output logic [RW-1:0]       numW,
  output logic [TW-1:0]       depW,
  output logic [DW-1:0]       dataW,
  output logic                cdbValid,
  output logic [TW-1:0]       cdbTag,
  output logic [DW-1:0]       cdbData
);

  localparam int PW   = (NFU > 1) ? $clog2(NFU) : 1;
  localparam int NREG = 1 << RW;

  // arbitration state
  logic [PW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [1:0]    wait_cnt_reg, wait_cnt_next;
  logic [TW-1:0] shadow_reg [NREG];

  // per-FU payload views
  logic [TW-1:0] fu_tag_arr  [NFU];
  logic [RW-1:0] fu_reg_arr  [NFU];
  logic [DW-1:0] fu_data_arr [NFU];

  genvar gi;
  generate
    for (gi = 0; gi < NFU; gi++) begin : g_unpack
      assign fu_tag_arr[gi]  = fuTag[gi*TW +: TW];
      assign fu_reg_arr[gi]  = fuReg[gi*RW +: RW];
      assign fu_data_arr[gi] = fuData[gi*DW +: DW];
    end
  endgenerate

  // round-robin scan results
  logic          fu_found;
  logic [PW-1:0] fu_sel;
  logic [PW-1:0] scan_idx;
  logic [PW:0]   scan_sum;
  logic [TW-1:0] sel_tag;
  logic [RW-1:0] sel_reg;
  logic [DW-1:0] sel_data;

  // find the first requesting FU at or above rr_ptr, wrapping mod NFU
  always_comb begin
    fu_found = 1'b0;
    fu_sel   = '0;
    scan_idx = '0;
    scan_sum = '0;
    sel_tag  = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int k = 0; k < NFU; k++) begin
      scan_sum = {1'b0, rr_ptr_reg} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NFU)) begin
        scan_sum = scan_sum - (PW+1)'(NFU);
      end
      scan_idx = scan_sum[PW-1:0];
      if (!fu_found && fuReq[scan_idx]) begin
        fu_found = 1'b1;
        fu_sel   = scan_idx;
        sel_tag  = fu_tag_arr[scan_idx];
        sel_reg  = fu_reg_arr[scan_idx];
        sel_data = fu_data_arr[scan_idx];
      end
    end
  end

  // grant decision; issue preempts FUs once it has waited two cycles
  logic issue_pri, issue_grant, fu_grant, shadow_hit;
  assign issue_pri   = issueReq && (wait_cnt_reg == 2'd2);
  assign issue_grant = !CLR && issueReq && (issue_pri || !fu_found);
  assign fu_grant    = !CLR && fu_found && !issue_pri;
  assign shadow_hit  = (shadow_reg[sel_reg] == sel_tag);

  assign issueAck = issue_grant;
  assign fuAck    = fu_grant ? (NFU'(1) << fu_sel) : '0;

  // next-state values for pointers, shadow write and output registers
  logic          shadow_we;
  logic [RW-1:0] shadow_waddr;
  logic [TW-1:0] shadow_wdata;
  logic          wren_next, cdb_valid_next;
  logic [RW-1:0] num_w_next;
  logic [TW-1:0] dep_w_next, cdb_tag_next;
  logic [DW-1:0] data_w_next, cdb_data_next;

  // compute the write-port / CDB contents for the transfer happening now
  always_comb begin
    rr_ptr_next    = rr_ptr_reg;
    wait_cnt_next  = wait_cnt_reg;
    shadow_we      = 1'b0;
    shadow_waddr   = '0;
    shadow_wdata   = '0;
    wren_next      = 1'b0;
    num_w_next     = '0;
    dep_w_next     = '0;
    data_w_next    = '0;
    cdb_valid_next = 1'b0;
    cdb_tag_next   = '0;
    cdb_data_next  = '0;

    if (!issueReq || issue_grant) begin
      wait_cnt_next = 2'd0;
    end else if (wait_cnt_reg != 2'd3) begin
      wait_cnt_next = wait_cnt_reg + 2'd1;
    end

    if (issue_grant && (issueTag != '0)) begin
      wren_next    = 1'b1;
      num_w_next   = issueReg;
      dep_w_next   = issueTag;
      shadow_we    = 1'b1;
      shadow_waddr = issueReg;
      shadow_wdata = issueTag;
    end

    if (fu_grant) begin
      rr_ptr_next = (fu_sel == PW'(NFU-1)) ? '0 : fu_sel + PW'(1);
      if (sel_tag != '0) begin
        cdb_valid_next = 1'b1;
        cdb_tag_next   = sel_tag;
        cdb_data_next  = sel_data;
        // only the current producer of the register may clear its tag
        if (shadow_hit) begin
          wren_next    = 1'b1;
          num_w_next   = sel_reg;
          data_w_next  = sel_data;
          shadow_we    = 1'b1;
          shadow_waddr = sel_reg;
          shadow_wdata = '0;
        end
      end
    end
  end

  // register arbitration state and outputs
  always_ff @(posedge CLK) begin
    if (CLR) begin
      rr_ptr_reg   <= '0;
      wait_cnt_reg <= 2'd0;
      wren         <= 1'b0;
      numW         <= '0;
      depW         <= '0;
      dataW        <= '0;
      cdbValid     <= 1'b0;
      cdbTag       <= '0;
      cdbData      <= '0;
    end else begin
      rr_ptr_reg   <= rr_ptr_next;
      wait_cnt_reg <= wait_cnt_next;
      wren         <= wren_next;
      numW         <= num_w_next;
      depW         <= dep_w_next;
      dataW        <= data_w_next;
      cdbValid     <= cdb_valid_next;
      cdbTag       <= cdb_tag_next;
      cdbData      <= cdb_data_next;
    end
  end

  // shadow dependency table, cleared on reset
  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int e = 0; e < NREG; e++) begin
        shadow_reg[e] <= '0;
      end
    end else if (shadow_we) begin
      shadow_reg[shadow_waddr] <= shadow_wdata;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic, every cycle
// checked against a rule-level reference model of the arbiter.
module tb_cdb_arbiter;
  localparam int NFU = 3;
  localparam int DW  = 16;
  localparam int TW  = 3;
  localparam int RW  = 3;

  logic                CLK, CLR;
  logic                issueReq, issueAck;
  logic [RW-1:0]       issueReg;
  logic [TW-1:0]       issueTag;
  logic [NFU-1:0]      fuReq, fuAck;
  logic [NFU*TW-1:0]   fuTag;
  logic [NFU*RW-1:0]   fuReg;
  logic [NFU*DW-1:0]   fuData;
  logic                wren, cdbValid;
  logic [RW-1:0]       numW;
  logic [TW-1:0]       depW, cdbTag;
  logic [DW-1:0]       dataW, cdbData;

  cdb_arbiter #(.NFU(NFU), .DW(DW), .TW(TW), .RW(RW)) dut (
    .CLK(CLK), .CLR(CLR),
    .issueReq(issueReq), .issueReg(issueReg), .issueTag(issueTag), .issueAck(issueAck),
    .fuReq(fuReq), .fuTag(fuTag), .fuReg(fuReg), .fuData(fuData), .fuAck(fuAck),
    .wren(wren), .numW(numW), .depW(depW), .dataW(dataW),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // stimulus state (the requesters)
  bit            s_clr;
  bit            s_ireq;
  logic [RW-1:0] s_ireg;
  logic [TW-1:0] s_itag;
  bit            s_freq  [NFU];
  logic [TW-1:0] s_ftag  [NFU];
  logic [RW-1:0] s_freg  [NFU];
  logic [DW-1:0] s_fdata [NFU];
  bit            refill;

  // reference model state
  int            m_rr;
  int            m_issue_waited;
  logic [TW-1:0] m_shadow [1<<RW];
  bit            e_known;
  logic          e_wren, e_cv;
  logic [RW-1:0] e_numw;
  logic [TW-1:0] e_depw, e_ctag;
  logic [DW-1:0] e_dataw, e_cdata;

  int             last_g;
  logic           o_iack;
  logic [NFU-1:0] o_fack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // one clock of traffic: drive, check acks and outputs, advance the model
  task automatic run_cycle();
    int g;
    logic [NFU-1:0] exp_fack;
    CLR      = s_clr;
    issueReq = s_ireq;
    issueReg = s_ireg;
    issueTag = s_itag;
    for (int j = 0; j < NFU; j++) begin
      fuReq[j]            = s_freq[j];
      fuTag[j*TW +: TW]   = s_ftag[j];
      fuReg[j*RW +: RW]   = s_freg[j];
      fuData[j*DW +: DW]  = s_fdata[j];
    end
    @(negedge CLK);
    if (e_known) begin
      check("wren", wren, e_wren);
      check("numW", numW, e_numw);
      check("depW", depW, e_depw);
      check("dataW", dataW, e_dataw);
      check("cdbValid", cdbValid, e_cv);
      check("cdbTag", cdbTag, e_ctag);
      check("cdbData", cdbData, e_cdata);
    end
    // who should win this cycle (g==NFU means issue)
    g = -1;
    if (!s_clr) begin
      if (s_ireq && m_issue_waited >= 2) g = NFU;
      else begin
        for (int k = 0; k < NFU; k++)
          if (g < 0 && s_freq[(m_rr + k) % NFU]) g = (m_rr + k) % NFU;
        if (g < 0 && s_ireq) g = NFU;
      end
    end
    exp_fack = '0;
    if (g >= 0 && g < NFU) exp_fack[g] = 1'b1;
    check("issueAck", issueAck, (g == NFU));
    check("fuAck", fuAck, exp_fack);
    o_iack = issueAck;
    o_fack = fuAck;
    e_wren = 0; e_numw = 0; e_depw = 0; e_dataw = 0; e_cv = 0; e_ctag = 0; e_cdata = 0;
    if (s_clr) begin
      m_rr = 0;
      m_issue_waited = 0;
      for (int r = 0; r < (1<<RW); r++) m_shadow[r] = '0;
      $display("cyc %0d reset", cyc);
    end else begin
      if (g == NFU) begin
        if (s_itag != 0) begin
          e_wren = 1; e_numw = s_ireg; e_depw = s_itag;
          m_shadow[s_ireg] = s_itag;
        end
        $display("cyc %0d issue reg=%0d tag=%0d", cyc, s_ireg, s_itag);
      end else if (g >= 0) begin
        if (s_ftag[g] != 0) begin
          e_cv = 1; e_ctag = s_ftag[g]; e_cdata = s_fdata[g];
          if (m_shadow[s_freg[g]] == s_ftag[g]) begin
            e_wren = 1; e_numw = s_freg[g]; e_dataw = s_fdata[g];
            m_shadow[s_freg[g]] = '0;
          end
        end
        m_rr = (g + 1) % NFU;
        $display("cyc %0d fu%0d tag=%0d reg=%0d data=%h", cyc, g, s_ftag[g], s_freg[g], s_fdata[g]);
      end
      if (s_ireq && g != NFU) m_issue_waited = (m_issue_waited < 3) ? m_issue_waited + 1 : 3;
      else m_issue_waited = 0;
    end
    e_known = 1;
    last_g = g;
    if (g == NFU) s_ireq = 0;
    else if (g >= 0 && !refill) s_freq[g] = 0;
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_issue(input logic [RW-1:0] r, input logic [TW-1:0] t);
    s_ireq = 1; s_ireg = r; s_itag = t;
    for (int n = 0; n < 8 && s_ireq; n++) run_cycle();
    if (s_ireq) begin
      check("issue_timeout", 0, 1);
      s_ireq = 0;
    end
  endtask

  task automatic do_complete(input int f, input logic [TW-1:0] t, input logic [RW-1:0] r,
                             input logic [DW-1:0] d);
    s_freq[f] = 1; s_ftag[f] = t; s_freg[f] = r; s_fdata[f] = d;
    for (int n = 0; n < 8 && s_freq[f]; n++) run_cycle();
    if (s_freq[f]) begin
      check("fu_timeout", 0, 1);
      s_freq[f] = 0;
    end
  endtask

  task automatic drain();
    bit busy;
    s_clr = 0;
    refill = 0;
    for (int n = 0; n < 12; n++) begin
      busy = s_ireq;
      for (int j = 0; j < NFU; j++) busy |= s_freq[j];
      if (busy) run_cycle();
    end
    busy = s_ireq;
    for (int j = 0; j < NFU; j++) busy |= s_freq[j];
    if (busy) begin
      check("drain_timeout", 0, 1);
      s_ireq = 0;
      for (int j = 0; j < NFU; j++) s_freq[j] = 0;
    end
  endtask

  initial begin
    int pg;
    logic [NFU-1:0] rr_exp [4];
    e_known = 0; refill = 0; m_rr = 0; m_issue_waited = 0;
    for (int r = 0; r < (1<<RW); r++) m_shadow[r] = '0;

    // reset with every request raised
    s_clr = 1; s_ireq = 1; s_ireg = 7; s_itag = 7;
    for (int j = 0; j < NFU; j++) begin
      s_freq[j] = 1; s_ftag[j] = 0; s_freg[j] = RW'(j); s_fdata[j] = DW'(16'h100 + j);
    end
    run_cycle();
    run_cycle();
    check("rst_wren", wren, 0);
    check("rst_cdbValid", cdbValid, 0);
    check("rst_dataW", dataW, 0);
    s_clr = 0;
    run_cycle();
    check("rst_first_fu0", o_fack, 3'b001);
    drain();

    // rename then complete
    do_issue(5, 3);
    check("ren_wren", wren, 1);
    check("ren_numW", numW, 5);
    check("ren_depW", depW, 3);
    do_complete(1, 3, 5, 16'h1234);
    check("cmp_cdbValid", cdbValid, 1);
    check("cmp_cdbTag", cdbTag, 3);
    check("cmp_wren", wren, 1);
    check("cmp_depW", depW, 0);
    check("cmp_dataW", dataW, 16'h1234);

    // stale completion
    do_issue(2, 1);
    do_issue(2, 4);
    do_complete(0, 1, 2, 16'hAAAA);
    check("stale_cdbValid", cdbValid, 1);
    check("stale_cdbTag", cdbTag, 1);
    check("stale_wren", wren, 0);
    do_complete(2, 4, 2, 16'hBBBB);
    check("fresh_wren", wren, 1);
    check("fresh_numW", numW, 2);

    // tag 0 completion
    do_complete(0, 0, 3, 16'h5555);
    check("tag0_ack", o_fack, 3'b001);
    check("tag0_cdbValid", cdbValid, 0);
    check("tag0_wren", wren, 0);

    // round-robin, each FU idles one cycle after its grant
    s_clr = 1;
    run_cycle();
    s_clr = 0;
    for (int j = 0; j < NFU; j++) begin
      s_freq[j] = 1; s_ftag[j] = 0;
    end
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    pg = -1;
    for (int c = 0; c < 4; c++) begin
      run_cycle();
      check("rr_order", o_fack, rr_exp[c]);
      if (pg >= 0 && pg < NFU) s_freq[pg] = 1;
      pg = last_g;
    end
    drain();

    // issue anti-starvation under continuous FU traffic
    for (int j = 0; j < NFU; j++) begin
      s_freq[j] = 1; s_ftag[j] = 0;
    end
    refill = 1;
    s_ireq = 1; s_ireg = 6; s_itag = 5;
    run_cycle();
    check("starve_c1", o_iack, 0);
    run_cycle();
    check("starve_c2", o_iack, 0);
    run_cycle();
    check("starve_c3", o_iack, 1);
    run_cycle();
    check("starve_resume", (o_fack != 0), 1);
    drain();

    // randomized traffic with occasional mid-operation resets
    for (int n = 0; n < 400; n++) begin
      int r;
      s_clr = ($urandom_range(0, 79) == 0);
      if (!s_ireq && $urandom_range(0, 9) < 3) begin
        s_ireq = 1;
        s_ireg = RW'($urandom_range(0, 7));
        s_itag = TW'($urandom_range(0, 7));
      end
      for (int j = 0; j < NFU; j++) begin
        if (!s_freq[j] && $urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 7);
          s_freq[j]  = 1;
          s_freg[j]  = RW'(r);
          s_ftag[j]  = ($urandom_range(0, 9) < 6) ? m_shadow[r] : TW'($urandom_range(0, 7));
          s_fdata[j] = DW'($urandom);
        end
      end
      run_cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter and write-port controller for the Tomasulo core. Shares the register file's single write port (wren/numW/depW/dataW) between the issue stage, which writes rename tags, and NFU functional units, which complete results. It also broadcasts each completion on the CDB for reservation-station wakeup. A shadow tag table suppresses register writes from stale completions whose destination has since been renamed.

## Interface
- NFU, 3, number of functional-unit requesters
- DW, 16, data width
- TW, 3, tag width; tag 0 means "no dependency"
- RW, 3, register index width (2^RW registers)

- CLK  in  1  clock; all state updates on posedge
- CLR  in  1  synchronous, active-high reset
- issueReq  in  1  issue stage requests a tag write
- issueReg  in  RW  destination register being renamed
- issueTag  in  TW  new producer tag (nonzero)
- issueAck  out  1  combinational; issue request granted this cycle
- fuReq  in  NFU  per-FU completion request
- fuTag  in  NFU*TW  per-FU producer tag; FU i occupies bits [i*TW +: TW]
- fuReg  in  NFU*RW  per-FU destination register
- fuData  in  NFU*DW  per-FU result
- fuAck  out  NFU  combinational one-hot grant; at most one bit set
- wren, numW, depW, dataW  out  1/RW/TW/DW  registered; connect to the register file write port
- cdbValid, cdbTag, cdbData  out  1/TW/DW  registered CDB broadcast

## Operation
- **Handshake.** A requester holds req and payload stable until it sees ack high. The ack cycle is the transfer. The requester may present a new request in the following cycle.
- **Grants.** At most one grant per cycle, across issue and all FUs combined.
- **Arbitration order:**
  1. If issueReq is high and waitCnt==2, grant issue.
  2. Otherwise, if any fuReq is set, grant the first set bit found by scanning from rrPtr upward, mod NFU.
  3. Otherwise, if issueReq is high, grant issue.
- **rrPtr.** After an FU i grant, rrPtr <= (i+1) mod NFU. Unchanged otherwise.
- **waitCnt** (2-bit, saturating):
  - Increments when issueReq is high and issueAck is low.
  - Cleared on an issue grant or when issueReq is low.
- **Shadow table** (2^RW entries of TW bits) mirrors the register file's dependency tags.
- **Issue grant** (issueTag != 0), next cycle:
  - wren=1, numW=issueReg, depW=issueTag, dataW=0, cdbValid=0.
  - shadow[issueReg] <= issueTag.
- **Issue grant with issueTag == 0:** acked; wren=0; shadow unchanged.
- **FU i grant** with tag t != 0 and register r, next cycle:
  - cdbValid=1, cdbTag=t, cdbData=data.
  - If shadow[r]==t: wren=1, numW=r, depW=0, dataW=data; shadow[r] <= 0.
  - If shadow[r]!=t (stale completion): wren=0; shadow unchanged.
- **FU grant with tag 0:** acked, all outputs idle.
- **No grant:** wren=0, cdbValid=0. numW/depW/dataW/cdbTag/cdbData are don't-care but held at 0.

## Timing
- **Reset values.** While CLR is high at posedge, all registered outputs go to 0, rrPtr=0, waitCnt=0, and all shadow entries=0.
- **Acks during reset.** issueAck and fuAck are forced to 0 while CLR is high. No transfer occurs in a reset cycle.
- **Reset mid-operation.** Requests pending at reset stay pending and are re-arbitrated starting from rrPtr=0.
- **Latency.** The ack cycle is N. Outputs are valid in cycle N+1, and the register file writes at the end of N+1.
- **Shadow visibility.** The shadow update takes effect at the end of cycle N and is visible to the arbitration in N+1. Back-to-back issue then completion to the same register is therefore checked correctly.
- **Throughput.** One transfer per cycle. Issue waits at most 2 cycles under continuous FU traffic. Each FU waits at most NFU-1 FU grants plus one issue grant.
- **Wrap-around.** rrPtr wraps from NFU-1 to 0.

## Test plan
- **Reset:** hold CLR 2 cycles with all requests high -> acks 0, all outputs 0. Release -> FU0 is granted first (rrPtr=0).
- **Rename then complete:**
  - Issue reg 5, tag 3 -> next cycle wren=1, numW=5, depW=3.
  - FU1 then completes tag 3, reg 5, data 0x1234 -> cdbValid=1, cdbTag=3, wren=1, depW=0, dataW=0x1234.
- **Stale completion:**
  - Issue reg 2 tag 1, then issue reg 2 tag 4.
  - FU0 completes tag 1, reg 2, data 0xAAAA -> cdbValid=1, cdbTag=1, wren=0.
  - FU2 then completes tag 4 -> wren=1, numW=2.
- **Round-robin:** fuReq=3'b111 held, each FU dropping req for one cycle after ack -> grant order FU0, FU1, FU2, FU0.
- **Issue anti-starvation:** fuReq=3'b111 continuously with issueReq high -> issueAck asserted in the 3rd cycle; the FU grant sequence resumes after it.
- **Tag 0:** FU request with tag 0 -> fuAck=1, next cycle cdbValid=0 and wren=0, shadow unchanged.
